dram_cmd_responder: RTL and testbench
=====================================

DRAM_CMD_RESPONDER -- requirements
Module: dram_cmd_responder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_OF_BANKS, 8, bank count.
- NUM_OF_ROWS, 128, rows per bank.
- NUM_OF_COLS, 8, columns per row.
- T_RCD, 3, activate latency in cycles (min 1).
- T_CAS, 2, read/write latency in cycles (min 1).
- T_RP, 3, precharge latency in cycles (min 1).

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- cmd_req, in, 1, controller command request.
- cmd, in, 2, 00 ACT, 01 RD, 10 WR, 11 PRE.
- bank_sel, in, NUM_OF_BANKS, one-hot bank.
- row_sel, in, NUM_OF_ROWS, one-hot row.
- col_sel, in, NUM_OF_COLS, one-hot column.
- cmd_ack, out, 1, command complete.
- cmd_err, out, 1, protocol error, valid while cmd_ack=1.
- array_en, out, 1, one-cycle storage-array strobe.
- bank_rw, out, 1, 1 = write array.
- buf_rw, out, 1, 1 = responder drives data bus.
- bank_id, out, clog2(NUM_OF_BANKS), encoded bank.
- row_id, out, clog2(NUM_OF_ROWS), encoded row.
- col_id, out, clog2(NUM_OF_COLS), encoded column.

REQ-003 One clock, clk. Reset rst is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, DECODE, WAIT, ACK.
REQ-005 Transitions:
- IDLE -> DECODE when cmd_req=1 is sampled.
- DECODE latches cmd and the encoded ids, then -> WAIT, or -> ACK on error.
- WAIT -> ACK when the latency counter expires.
- ACK -> IDLE when cmd_req=0 is sampled.
REQ-006 Latency, counting the cycle cmd_req is first sampled as cycle 0: WAIT lasts T cycles (ACT T_RCD, RD/WR T_CAS, PRE T_RP), and cmd_ack is first high in cycle T+2.
REQ-007 Handshake: cmd_ack stays high through ACK and falls the cycle after cmd_req=0 is sampled. cmd_req dropping before ack does not abort the command; ack then pulses for exactly one cycle.
REQ-008 Per-bank open-row table, one open flag plus row id per bank:
- ACT sets the bank's flag and row.
- PRE clears the flag.
- Both updates take effect in the final WAIT cycle.
REQ-009 Errors (cmd_err=1, ack in cycle 2, table unchanged, no array_en):
- ACT on an already-open bank.
- RD/WR on a closed bank.
- RD/WR whose row differs from the bank's open row.
- PRE on a closed bank.
REQ-010 RD/WR pulse array_en in the final WAIT cycle, with row_id taken from the open-row table.
- WR: bank_rw=1, buf_rw=0.
- RD: bank_rw=0, buf_rw=1.
- buf_rw holds until cmd_ack falls.
REQ-011 bank_id/row_id/col_id hold the latched values from DECODE until the next DECODE.
REQ-012 cmd_req held high continuously across ACK -> IDLE is not treated as a new command until it has been seen low.

Reset
REQ-013 Reset state:
- FSM to IDLE and counter to 0.
- All open flags cleared.
- cmd_ack, cmd_err, array_en, bank_rw, buf_rw at 0.
- All ids at 0.
REQ-014 Reset mid-command abandons the command, and no array_en is emitted in the reset cycle.

Configuration
REQ-015 Macro DRAM_RESP_ONEHOT_CHECK_EN:
- Defined: any select that is zero or multi-hot gives a cmd_err response per REQ-009.
- Undefined: the lowest set bit is used, all-zero encodes to 0, and no error is raised.

Structure
REQ-016 Package dram_resp_pkg holds:
- cmd encoding constants.
- FSM state typedef.
- Default timing constants.
REQ-017 Sub-module onehot_enc (parameterised width) SHALL be instantiated three times for bank/row/col. It outputs the encoded index plus a valid (exactly-one-hot) flag.

Verification
REQ-018 The bench SHALL cover these directed scenarios (defaults):
- Reset, then ACT bank_sel=8'h04, row_sel bit 5 -> cmd_ack high in cycle 5, bank_id=2, row_id=5, cmd_err=0.
- After the above, WR col_sel=8'h08 -> array_en pulse in cycle 3, bank_rw=1, col_id=3, cmd_ack in cycle 4.
- RD on closed bank 0 -> cmd_ack in cycle 2 with cmd_err=1, no array_en.
- ACT bank 2 again while open -> cmd_err=1. Then PRE bank 2 -> cmd_ack in cycle 5, cmd_err=0. Then RD bank 2 -> cmd_err=1.
- With the macro defined, bank_sel=8'h06 -> cmd_err=1. Without it -> bank_id=1, no error.
- rst asserted in a WAIT cycle of ACT -> next cycle all outputs 0, and a subsequent RD to that bank errors.

Source files
------------

// File: rtl/dram_resp_pkg.sv
// ---------------------------------------------------------------------------
// dram_resp_pkg
// Shared definitions for the DRAM command responder: command encodings, the
// responder FSM state type, default geometry/timing values and a helper that
// sizes encoded-index fields.
// ---------------------------------------------------------------------------
package dram_resp_pkg;

  // Command encodings carried on the 2-bit cmd bus.
  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  // Responder FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  // Default geometry and timing (latencies in clk cycles).
  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;
  localparam int DEF_T_RCD        = 3;
  localparam int DEF_T_CAS        = 2;
  localparam int DEF_T_RP         = 3;

  // Bits needed to hold an index 0..n-1; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// ---------------------------------------------------------------------------
// onehot_enc
// One-hot to binary encoder. The lowest set bit wins, so a multi-hot input
// still yields a usable index and an all-zero input encodes to 0.
// Ports:
//   sel_i   [W-1:0]   one-hot select
//   idx_o   [IW-1:0]  index of the lowest set bit (0 when none set)
//   valid_o           1 when exactly one bit of sel_i is set
// ---------------------------------------------------------------------------
module onehot_enc #(
  parameter  int W  = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  sel_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int hits;

  // Scan from the top down so the last match written is the lowest bit.
  always_comb begin
    idx_o = '0;
    hits  = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (sel_i[i]) begin
        idx_o = i[IW-1:0];
        hits  = hits + 1;
      end
    end
  end

  assign valid_o = (hits == 1);

endmodule

// File: rtl/dram_cmd_responder.sv
// ---------------------------------------------------------------------------
// dram_cmd_responder
// Memory-side responder for a simple DRAM command protocol. Tracks one open
// row per bank, checks each command against that table, waits the command's
// latency and strobes the storage array for reads and writes.
//
// Handshake: cmd_req/cmd_ack is a four-phase level handshake. The controller
// raises cmd_req with cmd and selects stable and keeps them stable at least
// until the cycle after cmd_req is first sampled; the responder raises
// cmd_ack (with cmd_err valid alongside it) once the command has completed
// and holds it until it samples cmd_req low. A cmd_req that drops early
// does not cancel the command; cmd_ack then pulses for one cycle. A new
// command is only accepted after cmd_req has been seen low.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_req, cmd[1:0]        request and command (ACT/RD/WR/PRE)
//   bank_sel/row_sel/col_sel one-hot bank/row/column selects
//   cmd_ack, cmd_err         completion, error flag (valid with cmd_ack)
//   array_en, bank_rw        one-cycle array strobe, 1 = array write
//   buf_rw                   1 = responder drives the data bus (reads)
//   bank_id/row_id/col_id    encoded ids latched at decode
//   dbg_state                current FSM state, for observation only
//
// Build option: define DRAM_RESP_ONEHOT_CHECK_EN to answer any zero or
// multi-hot select with an error; otherwise the lowest set bit is used.
// ---------------------------------------------------------------------------
module dram_cmd_responder
  import dram_resp_pkg::*;
#(
  parameter  int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter  int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter  int NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter  int T_RCD        = DEF_T_RCD,
  parameter  int T_CAS        = DEF_T_CAS,
  parameter  int T_RP         = DEF_T_RP,
  localparam int BW           = id_width(NUM_OF_BANKS),
  localparam int RW           = id_width(NUM_OF_ROWS),
  localparam int CW           = id_width(NUM_OF_COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic                    array_en,
  output logic                    bank_rw,
  output logic                    buf_rw,
  output logic [BW-1:0]           bank_id,
  output logic [RW-1:0]           row_id,
  output logic [CW-1:0]           col_id,
  output logic [1:0]              dbg_state
);

  localparam int T_MAX = (T_RCD > T_CAS) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                         : ((T_CAS > T_RP) ? T_CAS : T_RP);
  localparam int CNT_W = id_width(T_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              err_q, err_d;
  logic [BW-1:0]     bank_id_q, bank_id_d;
  logic [RW-1:0]     row_id_q, row_id_d;
  logic [CW-1:0]     col_id_q, col_id_d;
  logic [NUM_OF_BANKS-1:0] open_q;
  logic [RW-1:0]     row_tbl_q [NUM_OF_BANKS];

  logic [BW-1:0]     bank_enc;
  logic [RW-1:0]     row_enc;
  logic [CW-1:0]     col_enc;
  logic              bank_ok, row_ok, col_ok;
  logic              dec_err, is_rdwr, last_wait;
  logic [CNT_W-1:0]  lat_m1;

  onehot_enc #(.W(NUM_OF_BANKS)) u_bank_enc (.sel_i(bank_sel), .idx_o(bank_enc), .valid_o(bank_ok));
  onehot_enc #(.W(NUM_OF_ROWS))  u_row_enc  (.sel_i(row_sel),  .idx_o(row_enc),  .valid_o(row_ok));
  onehot_enc #(.W(NUM_OF_COLS))  u_col_enc  (.sel_i(col_sel),  .idx_o(col_enc),  .valid_o(col_ok));

`ifndef DRAM_RESP_ONEHOT_CHECK_EN
  logic sel_unused;
  assign sel_unused = &{1'b0, bank_ok, row_ok, col_ok};
`endif

  assign is_rdwr = (cmd == CMD_RD) || (cmd == CMD_WR);

  // Protocol check against the open-row table; only meaningful in DECODE,
  // where the controller guarantees cmd and selects are stable.
  always_comb begin
    dec_err = 1'b0;
    case (cmd)
      CMD_ACT: dec_err = open_q[bank_enc];
      CMD_PRE: dec_err = !open_q[bank_enc];
      default: dec_err = !open_q[bank_enc] || (row_tbl_q[bank_enc] != row_enc);
    endcase
`ifdef DRAM_RESP_ONEHOT_CHECK_EN
    if (!(bank_ok && row_ok && col_ok)) dec_err = 1'b1;
`endif
  end

  // The counter is loaded with T-1 so it reads zero in the final WAIT cycle.
  always_comb begin
    case (cmd)
      CMD_ACT: lat_m1 = CNT_W'(T_RCD - 1);
      CMD_PRE: lat_m1 = CNT_W'(T_RP - 1);
      default: lat_m1 = CNT_W'(T_CAS - 1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    bank_id_d = bank_id_q;
    row_id_d  = row_id_q;
    col_id_d  = col_id_q;
    case (state_q)
      S_IDLE: if (cmd_req) state_d = S_DECODE;
      S_DECODE: begin
        cmd_d     = cmd;
        err_d     = dec_err;
        bank_id_d = bank_enc;
        row_id_d  = (is_rdwr && !dec_err) ? row_tbl_q[bank_enc] : row_enc;
        col_id_d  = col_enc;
        cnt_d     = lat_m1;
        state_d   = dec_err ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACK: if (!cmd_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= CMD_ACT;
      err_q     <= 1'b0;
      bank_id_q <= '0;
      row_id_q  <= '0;
      col_id_q  <= '0;
      open_q    <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) row_tbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      bank_id_q <= bank_id_d;
      row_id_q  <= row_id_d;
      col_id_q  <= col_id_d;
      // Errored commands skip WAIT, so the table only moves on good ones.
      if (last_wait) begin
        if (cmd_q == CMD_ACT) begin
          open_q[bank_id_q]    <= 1'b1;
          row_tbl_q[bank_id_q] <= row_id_q;
        end else if (cmd_q == CMD_PRE) begin
          open_q[bank_id_q] <= 1'b0;
        end
      end
    end
  end

  assign last_wait = (state_q == S_WAIT) && (cnt_q == '0);

  // Array-side strobes are masked by rst so an abandoned command never
  // touches the array in the reset cycle.
  assign array_en  = !rst && last_wait && ((cmd_q == CMD_RD) || (cmd_q == CMD_WR));
  assign bank_rw   = array_en && (cmd_q == CMD_WR);
  assign buf_rw    = !rst && !err_q && (cmd_q == CMD_RD) &&
                     (last_wait || (state_q == S_ACK));
  assign cmd_ack   = (state_q == S_ACK);
  assign cmd_err   = cmd_ack && err_q;
  assign bank_id   = bank_id_q;
  assign row_id    = row_id_q;
  assign col_id    = col_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
`timescale 1ns/1ps
module tb_dram_cmd_responder;

  localparam int NB = 8, NR = 128, NC = 8;
  localparam int TRCD = 3, TCAS = 2, TRP = 3;
  localparam logic [1:0] C_ACT = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_PRE = 2'b11;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, cmd_req;
  logic [1:0]    cmd;
  logic [NB-1:0] bank_sel;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_sel;
  logic          cmd_ack, cmd_err, array_en, bank_rw, buf_rw;
  logic [2:0]    bank_id;
  logic [6:0]    row_id;
  logic [2:0]    col_id;
  logic [1:0]    unused_dbg_state;

  always #5 clk = ~clk;

  dram_cmd_responder #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(TRCD), .T_CAS(TCAS), .T_RP(TRP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .array_en(array_en),
    .bank_rw(bank_rw), .buf_rw(buf_rw), .bank_id(bank_id),
    .row_id(row_id), .col_id(col_id), .dbg_state(unused_dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       ack, err, en, brw, bufrw;
    logic [2:0] bank;
    logic [6:0] row;
    logic [2:0] col;
    logic [7:0] tc;   // cycle within command; FE/FF for reset/idle cycles
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  // First ack / first strobe seen in the current command.
  int obs_ack_tc, obs_err, obs_bank, obs_row, obs_en_tc, obs_brw, obs_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_open [NB];
  int m_row  [NB];
  int m_bank, m_rowid, m_col;

  function automatic int low8(input logic [7:0] v);
    int r = 0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int low128(input logic [127:0] v);
    int r = 0;
    for (int i = 127; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push_quiet(input logic [7:0] tc);
    exp_t e;
    e       = '0;
    e.bank  = m_bank[2:0];
    e.row   = m_rowid[6:0];
    e.col   = m_col[2:0];
    e.tc    = tc;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
    m_bank = 0; m_rowid = 0; m_col = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      cmd_req  = 1'b0;
      cmd      = 2'($urandom);
      bank_sel = 8'($urandom);
      row_sel  = {$urandom, $urandom, $urandom, $urandom};
      col_sel  = 8'($urandom);
      push_quiet(8'hFF);
    end
    #4;
  endtask

  // One command from the first cmd_req cycle (cycle 0) to the cycle after
  // which the responder is idle again. early: drop cmd_req before the ack.
  // extra: cycles cmd_req stays high past the first ack cycle.
  // want_rst: assert rst in a random WAIT cycle of a good command.
  task automatic do_cmd(input logic [1:0] c, input logic [NB-1:0] bs,
                        input logic [NR-1:0] rs, input logic [NC-1:0] cs,
                        input bit early, input int extra, input bit want_rst);
    int   b, r, co, lat, ack_c, last_c, hold_c, end_c, rst_c;
    bit   err, rdwr;
    exp_t e;
    b    = low8(bs);
    r    = low128(rs);
    co   = low8(cs);
    rdwr = (c == C_RD) || (c == C_WR);
    case (c)
      C_ACT:   err = m_open[b];
      C_PRE:   err = !m_open[b];
      default: err = !m_open[b] || (m_row[b] != r);
    endcase
`ifdef DRAM_RESP_ONEHOT_CHECK_EN
    if ($countones(bs) != 1 || $countones(rs) != 1 || $countones(cs) != 1) err = 1'b1;
`endif
    lat    = (c == C_ACT) ? TRCD : (c == C_PRE) ? TRP : TCAS;
    ack_c  = err ? 2 : lat + 2;
    last_c = err ? -1 : lat + 1;
    hold_c = early ? int'($urandom_range(ack_c - 1, 0)) : ack_c + extra;
    end_c  = early ? ack_c : ack_c + extra + 1;
    rst_c  = (want_rst && !err) ? int'($urandom_range(last_c, 2)) : -1;

    for (int tc = 0; tc <= end_c; tc++) begin
      @(negedge clk);
      if (tc == 0) begin
        cmd = c; bank_sel = bs; row_sel = rs; col_sel = cs;
      end
      cmd_req = (tc <= hold_c);
      rst     = (tc == rst_c);
      e.tc    = tc[7:0];
      e.ack   = (tc >= ack_c);
      e.err   = e.ack && err;
      e.en    = rdwr && (tc == last_c) && (tc != rst_c);
      e.brw   = e.en && (c == C_WR);
      e.bufrw = (c == C_RD) && !err && (tc >= last_c) && (tc != rst_c);
      e.bank  = (tc >= 2) ? b[2:0]  : m_bank[2:0];
      e.row   = (tc >= 2) ? r[6:0]  : m_rowid[6:0];
      e.col   = (tc >= 2) ? co[2:0] : m_col[2:0];
      exp_q.push_back(e);
      if (tc == rst_c) break;
    end

    if (rst_c >= 0) begin
      model_reset();
      @(negedge clk);
      rst     = 1'b0;
      cmd_req = 1'b0;
      push_quiet(8'hFE);
    end else begin
      m_bank = b; m_rowid = r; m_col = co;
      if (!err && c == C_ACT) begin
        m_open[b] = 1'b1;
        m_row[b]  = r;
      end else if (!err && c == C_PRE) begin
        m_open[b] = 1'b0;
      end
    end
    #4;
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cmd_ack",  32'(cmd_ack),  32'(e.ack));
        chk("cmd_err",  32'(cmd_err),  32'(e.err));
        chk("array_en", 32'(array_en), 32'(e.en));
        chk("bank_rw",  32'(bank_rw),  32'(e.brw));
        chk("buf_rw",   32'(buf_rw),   32'(e.bufrw));
        chk("bank_id",  32'(bank_id),  32'(e.bank));
        chk("row_id",   32'(row_id),   32'(e.row));
        chk("col_id",   32'(col_id),   32'(e.col));
        if (e.tc == 8'd0) begin
          obs_ack_tc = -1;
          obs_en_tc  = -1;
        end
        if (e.tc < 8'hFE && cmd_ack === 1'b1 && obs_ack_tc < 0) begin
          obs_ack_tc = int'(e.tc);
          obs_err    = int'(cmd_err);
          obs_bank   = int'(bank_id);
          obs_row    = int'(row_id);
        end
        if (e.tc < 8'hFE && array_en === 1'b1 && obs_en_tc < 0) begin
          obs_en_tc = int'(e.tc);
          obs_brw   = int'(bank_rw);
          obs_col   = int'(col_id);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NB-1:0] bs;
    logic [NR-1:0] rs;
    logic [NC-1:0] cs;
    logic [1:0]    c;
    int            b;

    rst = 1'b1; cmd_req = 1'b0; cmd = C_ACT;
    bank_sel = '0; row_sel = '0; col_sel = '0;
    model_reset();
    obs_ack_tc = -1; obs_en_tc = -1;
    obs_err = 0; obs_bank = 0; obs_row = 0; obs_brw = 0; obs_col = 0;

    // Reset: outputs and ids must read zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = (i < 2);
      push_quiet(8'hFE);
    end
    #4;

    // ACT bank 2, row 5.
    rs = '0; rs[5] = 1'b1;
    do_cmd(C_ACT, 8'h04, rs, 8'h01, 1'b0, 1, 1'b0);
    chk("act_ack_cycle", obs_ack_tc, 5);
    chk("act_bank_id",   obs_bank, 2);
    chk("act_row_id",    obs_row, 5);
    chk("act_err",       obs_err, 0);

    // WR to the open row, column 3.
    do_cmd(C_WR, 8'h04, rs, 8'h08, 1'b0, 0, 1'b0);
    chk("wr_en_cycle",  obs_en_tc, 3);
    chk("wr_bank_rw",   obs_brw, 1);
    chk("wr_col_id",    obs_col, 3);
    chk("wr_ack_cycle", obs_ack_tc, 4);

    // RD to the open row with cmd_req dropped early: one-cycle ack.
    do_cmd(C_RD, 8'h04, rs, 8'h02, 1'b1, 0, 1'b0);
    chk("rd_early_ack_cycle", obs_ack_tc, 4);

    // RD on closed bank 0.
    do_cmd(C_RD, 8'h01, rs, 8'h01, 1'b0, 0, 1'b0);
    chk("rd_closed_ack_cycle", obs_ack_tc, 2);
    chk("rd_closed_err",       obs_err, 1);
    chk("rd_closed_no_en",     obs_en_tc, -1);
    idle(2);

    // ACT on open bank 2, PRE bank 2, then RD bank 2.
    do_cmd(C_ACT, 8'h04, rs, 8'h01, 1'b0, 0, 1'b0);
    chk("act_open_err", obs_err, 1);
    do_cmd(C_PRE, 8'h04, rs, 8'h01, 1'b0, 2, 1'b0);
    chk("pre_ack_cycle", obs_ack_tc, 5);
    chk("pre_err",       obs_err, 0);
    do_cmd(C_RD, 8'h04, rs, 8'h01, 1'b0, 0, 1'b0);
    chk("rd_after_pre_err", obs_err, 1);

    // Multi-hot bank select.
    rs = '0; rs[7] = 1'b1;
    do_cmd(C_ACT, 8'h06, rs, 8'h01, 1'b0, 0, 1'b0);
`ifdef DRAM_RESP_ONEHOT_CHECK_EN
    chk("multihot_err", obs_err, 1);
`else
    chk("multihot_err",     obs_err, 0);
    chk("multihot_bank_id", obs_bank, 1);
`endif

    // Reset during WAIT of ACT bank 3, then RD bank 3 must fail.
    rs = '0; rs[9] = 1'b1;
    do_cmd(C_ACT, 8'h08, rs, 8'h01, 1'b0, 0, 1'b1);
    do_cmd(C_RD, 8'h08, rs, 8'h01, 1'b0, 0, 1'b0);
    chk("rd_after_rst_err",       obs_err, 1);
    chk("rd_after_rst_ack_cycle", obs_ack_tc, 2);

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++) begin
      b  = int'($urandom_range(NB - 1, 0));
      c  = 2'($urandom);
      if ($urandom_range(2, 0) == 0) c = C_ACT;
      bs = '0; bs[b] = 1'b1;
      rs = '0;
      if ((c == C_RD || c == C_WR) && m_open[b] && $urandom_range(3, 0) != 0)
        rs[m_row[b]] = 1'b1;
      else
        rs[$urandom_range(NR - 1, 0)] = 1'b1;
      cs = '0; cs[$urandom_range(NC - 1, 0)] = 1'b1;
      if ($urandom_range(15, 0) == 0) bs = 8'($urandom);
      if ($urandom_range(31, 0) == 0) cs = '0;
      do_cmd(c, bs, rs, cs, $urandom_range(3, 0) == 0,
             int'($urandom_range(3, 0)), $urandom_range(11, 0) == 0);
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
    end

    idle(2);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
